dff_write_arbiter: RTL
======================

// Module: dff_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing one WIDTH-bit D-flip-flop storage register among N writers.
//  Each writer raises req with its data; the block grants one writer at a time and commits its data to q.
//  A COMMIT phase separates grant from the next grant, matching the master/slave two-phase register use.
//  Sits between the register-file clients and the shared storage register.
// PARAMETERS
//  N      4  number of requesters, N >= 2
//  WIDTH  8  bits per data word / width of shared register
//  IW     $clog2(N)  owner index width (localparam, derived)
// PORTS
//  clk    in   1        rising-edge clock
//  rst_n  in   1        asynchronous active-low reset
//  req    in   N        per-requester write request, level; held until own gnt bit seen
//  wdata  in   N*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
//  gnt    out  N        one-hot grant, high exactly one cycle per accepted write
//  q      out  WIDTH    shared register contents
//  q_vld  out  1        one-cycle pulse: q updated this cycle
//  owner  out  IW       index of last committed writer
//  busy   out  1        high in GRANT or COMMIT
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=0, q=0, q_vld=0, owner=0, busy=0, rr pointer=0.
//  FSM, all outputs registered:
//   IDLE:   req!=0 -> GRANT; winner = first set req bit at/after pointer, wrapping N-1 -> 0.
//   GRANT:  gnt[winner]=1 for this cycle; wdata[winner] captured into hold reg at cycle end -> COMMIT.
//   COMMIT: q <= hold, q_vld=1, owner=winner, pointer <= (winner+1) mod N; never grants.
//           Next state: req (sampled this cycle, winner bit excluded unless reset it still requests) !=0 -> GRANT,
//           else IDLE.
//  Latency: req high in IDLE at edge t -> gnt at t+1 -> q/q_vld at t+2. Throughput 1 write per 2 cycles.
//  Requester must drop req in cycle after seeing gnt; req still high then counts as new request.
//  req dropped before grant: withdrawn, no write. wdata sampled only in GRANT cycle.
//  Simultaneous requests: only round-robin winner granted; losers keep req, served in pointer order.
//  Fairness: with all N requesting, each granted once in any N consecutive grants.
//  Pointer wrap: winner N-1 -> pointer 0.
//  Reset mid-GRANT/COMMIT: transaction aborted, q returns to 0, no q_vld pulse.
//  gnt never has more than one bit set; gnt=0 outside GRANT.
// CONFIGURATION
//  DFF_ARB_LOCK_EN defined: extra input lock (1 bit). If lock=1 in GRANT cycle, pointer
//   is not advanced in COMMIT, so the same writer wins again next GRANT if its req is high.
//  DFF_ARB_LOCK_EN undefined: no lock port; pure round-robin as above.
// STRUCTURE
//  Shared package dff_ctrl_pkg: state encoding (IDLE=2'b00, GRANT=2'b01, COMMIT=2'b10),
//   round-robin pick function (req, pointer) -> one-hot + index.
//  Sub-module dff_word_reg: WIDTH-bit async-reset register with load enable, used for q and hold.
//  FSM, pointer and grant logic stay in this module.
// TESTING (N=4, WIDTH=8)
//  Reset: rst_n=0 -> gnt=0, q=8'h00, q_vld=0, owner=0, busy=0.
//  Single: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 at t+1, q=8'hA5, q_vld=1, owner=2 at t+2.
//  Contention: req=4'b1010 from reset -> grants 4'b0010 then 4'b1000, q = data1 then data3.
//  Fairness/wrap: req=4'b1111 held -> grant order 0,1,2,3,0; never 2 grants in adjacent cycles.
//  Reset mid-op: rst_n=0 during COMMIT -> q=0, q_vld stays 0, next grant starts at requester 0.
//  Lock (DFF_ARB_LOCK_EN): req=4'b0011 held, lock=1 on grant to 0 -> second grant again to 0.

Source files
------------

// File: rtl/dff_ctrl_pkg.sv
// dff_ctrl_pkg: FSM state encoding and round-robin pick shared by the write arbiter.
package dff_ctrl_pkg;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GRANT  = 2'b01;
    localparam logic [1:0] COMMIT = 2'b10;
    localparam int MAX_N  = 32;
    localparam int MAX_IW = 5;
    typedef struct packed {
        logic              any;
        logic [MAX_IW-1:0] idx;
        logic [MAX_N-1:0]  onehot;
    } pick_t;
    // Scanning downwards means the last hit is the closest set bit at/after ptr.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req, input int unsigned ptr, input int unsigned n);
        pick_t p;
        int unsigned j;
        logic [MAX_IW-1:0] jj;
        p = '0;
        for (int k = MAX_N - 1; k >= 0; k--) begin
            j = (ptr + unsigned'(k)) % n;
            jj = MAX_IW'(j);
            if (unsigned'(k) < n && req[jj]) begin
                p.any = 1'b1;
                p.idx = jj;
                p.onehot = '0;
                p.onehot[jj] = 1'b1;
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/dff_write_arbiter_if.sv
// dff_write_arbiter_if: requester/arbiter bundle; lock exists only with DFF_ARB_LOCK_EN.
interface dff_write_arbiter_if #(parameter int N = 4, parameter int WIDTH = 8);
    localparam int IW = $clog2(N);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       gnt;
    logic [WIDTH-1:0]   q;
    logic               q_vld;
    logic [IW-1:0]      owner;
    logic               busy;
`ifdef DFF_ARB_LOCK_EN
    logic               lock;
    modport master (output req, wdata, lock, input gnt, q, q_vld, owner, busy);
    modport slave  (input req, wdata, lock, output gnt, q, q_vld, owner, busy);
`else
    modport master (output req, wdata, input gnt, q, q_vld, owner, busy);
    modport slave  (input req, wdata, output gnt, q, q_vld, owner, busy);
`endif
endinterface

// File: rtl/dff_word_reg.sv
// dff_word_reg: WIDTH-bit register with load enable and asynchronous active-low clear.
module dff_word_reg #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin sharing of one storage word among N writers (IDLE/GRANT/COMMIT).
// Define DFF_ARB_LOCK_EN to add a lock input that holds the round-robin pointer on the current winner.
module dff_write_arbiter
    import dff_ctrl_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    dff_write_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);
    logic [1:0]       state, state_nx;
    logic [IW-1:0]    ptr, win, win_inc, ptr_nx;
    logic [WIDTH-1:0] wsel;
    logic             lock_now, unused_pick;
    pick_t            p;
`ifdef DFF_ARB_LOCK_EN
    assign lock_now = bus.lock;
`else
    assign lock_now = 1'b0;
`endif
    assign p           = rr_pick(MAX_N'(bus.req), 32'(ptr), N);
    assign unused_pick = ^p;
    assign win_inc     = (win == IW'(N - 1)) ? '0 : win + 1'b1;
    assign ptr_nx      = lock_now ? win : win_inc;
    assign wsel        = bus.wdata[int'(win)*WIDTH +: WIDTH];
    assign state_nx    = (state == GRANT) ? COMMIT : (p.any ? GRANT : IDLE);
    // Pointer moves at the end of GRANT so the COMMIT-cycle pick already sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            bus.gnt   <= '0;
            bus.q_vld <= 1'b0;
            bus.owner <= '0;
            bus.busy  <= 1'b0;
        end else begin
            state     <= state_nx;
            bus.busy  <= state_nx != IDLE;
            bus.gnt   <= (state_nx == GRANT) ? p.onehot[N-1:0] : '0;
            win       <= (state_nx == GRANT) ? p.idx[IW-1:0] : win;
            bus.q_vld <= state == GRANT;
            if (state == GRANT) begin
                bus.owner <= win;
                ptr       <= ptr_nx;
            end
        end
    end
    // The winner's word is captured straight into q so it is visible in the COMMIT cycle.
    dff_word_reg #(.WIDTH(WIDTH)) u_q (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == GRANT),
        .d     (wsel),
        .q     (bus.q)
    );
endmodule
